// File: rtl/regex_stream_ctx_mgr.sv
// regex_stream_ctx_mgr
//   Context manager sitting in front of a single DFA regex engine. Each packet
//   belongs to a stream; the DFA state reached at the end of a cleanly retired,
//   enabled packet is saved per stream and restored when that stream's next
//   packet starts, so patterns can span packet boundaries. A per-packet
//   speculative match flag is counted only when the packet commits.
//
//   Ports
//     clk, rst_n                  clock, synchronous active-low reset
//     sop, stream_id, enable      packet start (taken while pkt_rdy=1)
//     char_in, char_vld, eop      payload bytes (taken while char_rdy=1)
//     abort                       drop the current packet (no save, no count)
//     clr_ctx                     invalidate every stream context
//     pkt_rdy, char_rdy           handshake readiness
//     dfa_char, dfa_char_vld      registered byte to the engine
//     dfa_state_in, dfa_state_ld  registered state restore to the engine
//     dfa_state_out, dfa_accept   engine outputs (registered here)
//     match                       speculative match of the current packet
//     commit, commit_hit          packet retire pulse and "match counted"
//     count                       saturating committed-match count
//
//   state  | meaning
//   IDLE   | waiting for sop
//   LOAD   | restore strobe to engine, clear speculative match
//   RUN    | accepting payload bytes
//   DRAIN  | letting the engine pipeline empty after eop/abort
//   COMMIT | retire packet, save context and count when allowed

module regex_stream_ctx_mgr #(
    parameter int STATE_W     = 11,
    parameter int NUM_STREAMS = 64,
    parameter int COUNT_W     = 16,
    parameter int DFA_LAT     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sop,
    input  logic [$clog2(NUM_STREAMS)-1:0] stream_id,
    input  logic                           enable,
    input  logic [7:0]                     char_in,
    input  logic                           char_vld,
    input  logic                           eop,
    input  logic                           abort,
    input  logic                           clr_ctx,
    output logic                           pkt_rdy,
    output logic                           char_rdy,
    output logic [7:0]                     dfa_char,
    output logic                           dfa_char_vld,
    output logic [STATE_W-1:0]             dfa_state_in,
    output logic                           dfa_state_ld,
    input  logic [STATE_W-1:0]             dfa_state_out,
    input  logic                           dfa_accept,
    output logic                           match,
    output logic                           commit,
    output logic                           commit_hit,
    output logic [COUNT_W-1:0]             count
);

    localparam int SID_W = $clog2(NUM_STREAMS);
    localparam int CNT_W = $clog2(DFA_LAT + 2);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DFA_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_COMMIT
    } state_t;

    state_t               state_q;
    logic [SID_W-1:0]     sid_q;
    logic                 en_q;
    logic                 abort_q;
    logic                 match_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [COUNT_W-1:0]   count_q;
    logic [NUM_STREAMS-1:0] ctx_vld_q;
    logic [7:0]           dfa_char_q;
    logic                 dfa_char_vld_q;
    logic [STATE_W-1:0]   dfa_state_in_q;
    logic                 dfa_state_ld_q;
    logic                 acc_q;
    logic [STATE_W-1:0]   st_q;
    logic [STATE_W-1:0]   mem_q [NUM_STREAMS];
    logic                 commit_ok;

    // Engine outputs are registered before use for timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
            st_q  <= '0;
        end else begin
            acc_q <= dfa_accept;
            st_q  <= dfa_state_out;
        end
    end

    assign commit_ok = en_q & ~abort_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            sid_q          <= '0;
            en_q           <= 1'b0;
            abort_q        <= 1'b0;
            match_q        <= 1'b0;
            cnt_q          <= '0;
            count_q        <= '0;
            ctx_vld_q      <= '0;
            dfa_char_q     <= '0;
            dfa_char_vld_q <= 1'b0;
            dfa_state_in_q <= '0;
            dfa_state_ld_q <= 1'b0;
        end else begin
            dfa_char_vld_q <= 1'b0;
            dfa_state_ld_q <= 1'b0;
            if (clr_ctx) begin
                ctx_vld_q <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (sop) begin
                        sid_q          <= stream_id;
                        en_q           <= enable;
                        abort_q        <= 1'b0;
                        dfa_state_ld_q <= 1'b1;
                        // The restore value is presented during LOAD, so a clear
                        // arriving now must already count as invalidating.
                        dfa_state_in_q <= (ctx_vld_q[stream_id] && !clr_ctx) ?
                                          mem_q[stream_id] : '0;
                        state_q        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    match_q <= 1'b0;
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    match_q <= match_q | acc_q;
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (char_vld) begin
                        dfa_char_q     <= char_in;
                        dfa_char_vld_q <= 1'b1;
                    end
                    if (abort || (char_vld && eop)) begin
                        cnt_q   <= DRAIN_INIT;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    match_q <= match_q | acc_q;
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q <= S_COMMIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (commit_ok) begin
                        if (!clr_ctx) begin
                            ctx_vld_q[sid_q] <= 1'b1;
                        end
                        if (match_q && (count_q != {COUNT_W{1'b1}})) begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Context RAM has no reset; validity is tracked by ctx_vld_q.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == S_COMMIT) && commit_ok) begin
            mem_q[sid_q] <= st_q;
        end
    end

    assign pkt_rdy      = (state_q == S_IDLE);
    assign char_rdy     = (state_q == S_RUN);
    assign commit       = (state_q == S_COMMIT);
    assign commit_hit   = commit & commit_ok & match_q;
    assign match        = match_q;
    assign count        = count_q;
    assign dfa_char     = dfa_char_q;
    assign dfa_char_vld = dfa_char_vld_q;
    assign dfa_state_in = dfa_state_in_q;
    assign dfa_state_ld = dfa_state_ld_q;

endmodule

// File: tb/tb_regex_stream_ctx_mgr.sv
// Bench for regex_stream_ctx_mgr: a toy DFA engine (substring "abcd") sits
// behind two DUT copies (COUNT_W=16 and COUNT_W=2). A per-stream context model
// predicts restore values, engine bytes, commit pulses and counts by cycle.
module tb_regex_stream_ctx_mgr;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sop, enable, char_vld, eop, abort, clr_ctx;
    logic [5:0]  stream_id;
    logic [7:0]  char_in;

    logic        pkt_rdy, char_rdy, dfa_char_vld, dfa_state_ld, match, commit, commit_hit;
    logic [7:0]  dfa_char;
    logic [10:0] dfa_state_in;
    logic [15:0] count;

    logic        pkt_rdy2, char_rdy2, dfa_char_vld2, dfa_state_ld2, match2, commit2, commit_hit2;
    logic [7:0]  dfa_char2;
    logic [10:0] dfa_state_in2;
    logic [1:0]  count2;

    logic [10:0] eng_state;
    logic        eng_acc;

    regex_stream_ctx_mgr #(.STATE_W(11), .NUM_STREAMS(64), .COUNT_W(16), .DFA_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .sop(sop), .stream_id(stream_id), .enable(enable),
        .char_in(char_in), .char_vld(char_vld), .eop(eop), .abort(abort), .clr_ctx(clr_ctx),
        .pkt_rdy(pkt_rdy), .char_rdy(char_rdy), .dfa_char(dfa_char), .dfa_char_vld(dfa_char_vld),
        .dfa_state_in(dfa_state_in), .dfa_state_ld(dfa_state_ld), .dfa_state_out(eng_state),
        .dfa_accept(eng_acc), .match(match), .commit(commit), .commit_hit(commit_hit), .count(count)
    );

    regex_stream_ctx_mgr #(.STATE_W(11), .NUM_STREAMS(64), .COUNT_W(2), .DFA_LAT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .sop(sop), .stream_id(stream_id), .enable(enable),
        .char_in(char_in), .char_vld(char_vld), .eop(eop), .abort(abort), .clr_ctx(clr_ctx),
        .pkt_rdy(pkt_rdy2), .char_rdy(char_rdy2), .dfa_char(dfa_char2), .dfa_char_vld(dfa_char_vld2),
        .dfa_state_in(dfa_state_in2), .dfa_state_ld(dfa_state_ld2), .dfa_state_out(eng_state),
        .dfa_accept(eng_acc), .match(match2), .commit(commit2), .commit_hit(commit_hit2), .count(count2)
    );

    // Substring matcher for "abcd": state = characters matched so far.
    function automatic int dfa_step(input int s, input int c);
        string pat;
        pat = "abcd";
        if (s < 4 && c == int'(pat[s])) return s + 1;
        if (c == int'(pat[0])) return 1;
        return 0;
    endfunction

    // Engine with one cycle of latency; accept pulses on the completing byte.
    always @(posedge clk) begin
        if (!rst_n) begin
            eng_acc   <= 1'b0;
            eng_state <= '0;
        end else begin
            eng_acc <= 1'b0;
            if (dfa_state_ld) begin
                eng_state <= dfa_state_in;
            end else if (dfa_char_vld) begin
                if (dfa_step(int'(eng_state), int'(dfa_char)) == 4) begin
                    eng_acc   <= 1'b1;
                    eng_state <= '0;
                end else begin
                    eng_state <= 11'(dfa_step(int'(eng_state), int'(dfa_char)));
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    bit mvld [64];
    int mmem [64];
    int mc1 = 0, mc2 = 0;
    int mcount = 0, mcount2 = 0;
    int last_ld = -1;
    int ld_exp [int];
    int chr_exp [int];
    int cm_exp [int];
    int mt_exp [int];
    int cnt_chg [int];
    int cnt2_chg [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (cnt_chg.exists(cyc))  mcount  = cnt_chg[cyc];
            if (cnt2_chg.exists(cyc)) mcount2 = cnt2_chg[cyc];
            chk("state_ld", 32'(dfa_state_ld), 32'(ld_exp.exists(cyc)));
            if (ld_exp.exists(cyc)) chk("state_in", 32'(dfa_state_in), 32'(ld_exp[cyc]));
            chk("char_vld", 32'(dfa_char_vld), 32'(chr_exp.exists(cyc)));
            if (chr_exp.exists(cyc)) chk("char", 32'(dfa_char), 32'(chr_exp[cyc]));
            chk("commit", 32'(commit), 32'(cm_exp.exists(cyc)));
            chk("commit_w2", 32'(commit2), 32'(cm_exp.exists(cyc)));
            if (cm_exp.exists(cyc)) begin
                chk("commit_hit", 32'(commit_hit), 32'(cm_exp[cyc]));
                chk("match", 32'(match), 32'(mt_exp[cyc]));
            end
            chk("count", 32'(count), 32'(mcount));
            chk("count_sat", 32'(count2), 32'(mcount2));
        end
    end

    // s: '-' is a bubble cycle (char_vld=0 with a stray eop).
    task automatic send_pkt(input int sid, input bit en, input string s, input int abort_idx,
                            input bit clr_at_commit, input bit spam_sop);
        int  guard, ld, st, e, ce, c;
        bit  hit, ok, aborted;
        guard = 0;
        while (!pkt_rdy && guard < 30) begin
            tick();
            guard++;
        end
        chk("pkt_rdy_wait", 32'(pkt_rdy), 32'd1);
        ld = mvld[sid] ? mmem[sid] : 0;
        last_ld = ld;
        sop = 1'b1; stream_id = 6'(sid); enable = en;
        ld_exp[cyc + 1] = ld;
        tick();
        sop = 1'b0;
        tick();
        chk("sop_to_char_rdy", 32'(char_rdy), 32'd1);
        st = ld; hit = 1'b0; e = cyc; aborted = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            c = int'(s[i]);
            sop = spam_sop;
            stream_id = 6'(sid ^ 1);
            if (c == int'("-")) begin
                char_vld = 1'b0;
                eop = 1'b1;
            end else begin
                char_vld = 1'b1;
                char_in = 8'(c);
                eop = (i == s.len() - 1);
                abort = (i == abort_idx);
                chr_exp[cyc + 1] = c;
                st = dfa_step(st, c);
                if (st == 4) begin
                    hit = 1'b1;
                    st = 0;
                end
                if (i == abort_idx || i == s.len() - 1) e = cyc;
            end
            tick();
            char_vld = 1'b0; eop = 1'b0; abort = 1'b0; sop = 1'b0;
            if (i == abort_idx) begin
                aborted = 1'b1;
                break;
            end
        end
        ce = e + 4;
        ok = en && !aborted;
        cm_exp[ce] = ok && hit;
        mt_exp[ce] = hit;
        if (ok && hit) begin
            mc1 = (mc1 < 65535) ? mc1 + 1 : mc1;
            mc2 = (mc2 < 3) ? mc2 + 1 : mc2;
            cnt_chg[ce + 1]  = mc1;
            cnt2_chg[ce + 1] = mc2;
        end
        while (cyc < ce) tick();
        clr_ctx = clr_at_commit;
        if (ok) begin
            mvld[sid] = 1'b1;
            mmem[sid] = st;
        end
        if (clr_at_commit) begin
            for (int k = 0; k < 64; k++) mvld[k] = 1'b0;
        end
        tick();
        clr_ctx = 1'b0;
        chk("back_to_idle", 32'(pkt_rdy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100us");
        $fatal(1);
    end

    int r;
    initial begin
        rst_n = 1'b0; sop = 1'b0; enable = 1'b0; char_vld = 1'b0; eop = 1'b0;
        abort = 1'b0; clr_ctx = 1'b0; stream_id = '0; char_in = '0;
        for (int k = 0; k < 64; k++) begin
            mvld[k] = 1'b0;
            mmem[k] = 0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_pkt_rdy", 32'(pkt_rdy), 32'd1);
        chk("rst_char_rdy", 32'(char_rdy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_commit_hit", 32'(commit_hit), 32'd0);
        tick();

        // New stream 5, match, ends mid-pattern ("ab")
        send_pkt(5, 1, "xabcdab", -1, 0, 0);
        chk("p1_load_lit", 32'(last_ld), 32'd0);
        chk("p1_count_lit", 32'(count), 32'd1);
        // Pattern spans packets on stream 5
        send_pkt(5, 1, "cdab", -1, 0, 0);
        chk("p2_load_lit", 32'(last_ld), 32'd2);
        chk("p2_count_lit", 32'(count), 32'd2);
        // Interleaved streams 9 and 12
        send_pkt(9, 1, "ab", -1, 0, 0);
        send_pkt(12, 1, "a-bc", -1, 0, 1);
        send_pkt(9, 1, "d", -1, 0, 0);
        chk("p5_load_lit", 32'(last_ld), 32'd2);
        send_pkt(12, 1, "d", -1, 0, 0);
        chk("p6_load_lit", 32'(last_ld), 32'd3);
        chk("p6_count_lit", 32'(count), 32'd3);
        // Disabled matching packet: no count, no save
        send_pkt(9, 0, "abcdab", -1, 0, 0);
        chk("p7_count_lit", 32'(count), 32'd3);
        send_pkt(9, 1, "c", -1, 0, 0);
        chk("p8_load_lit", 32'(last_ld), 32'd0);
        // Abort mid-packet, then bulk clear
        send_pkt(5, 1, "abcdabc", 5, 0, 0);
        chk("p9_count_lit", 32'(count), 32'd3);
        send_pkt(5, 1, "c", -1, 0, 0);
        chk("p10_load_lit", 32'(last_ld), 32'd2);
        clr_ctx = 1'b1;
        for (int k = 0; k < 64; k++) mvld[k] = 1'b0;
        tick();
        clr_ctx = 1'b0;
        send_pkt(5, 1, "d", -1, 0, 0);
        chk("p11_load_lit", 32'(last_ld), 32'd0);
        // Clear coincident with commit write
        send_pkt(20, 1, "ab", -1, 1, 0);
        send_pkt(20, 1, "cd", -1, 0, 0);
        chk("p13_load_lit", 32'(last_ld), 32'd0);
        // More matches to saturate the 2-bit counter
        for (int n = 0; n < 3; n++) send_pkt(30, 1, "abcdab", -1, 0, 0);
        chk("sat_count_lit", 32'(count), 32'd6);
        chk("sat_count2_lit", 32'(count2), 32'd3);

        // Reset in the middle of a packet
        sop = 1'b1; stream_id = 6'd7; enable = 1'b1;
        ld_exp[cyc + 1] = 0;
        tick();
        sop = 1'b0;
        tick();
        char_vld = 1'b1; char_in = "a"; chr_exp[cyc + 1] = "a";
        tick();
        char_in = "b"; chr_exp[cyc + 1] = "b";
        tick();
        char_vld = 1'b0;
        rst_n = 1'b0;
        r = cyc;
        cnt_chg[r + 1] = 0; cnt2_chg[r + 1] = 0;
        mc1 = 0; mc2 = 0;
        for (int k = 0; k < 64; k++) mvld[k] = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_idle", 32'(pkt_rdy), 32'd1);
        repeat (6) tick();
        chk("rst_mid_count_lit", 32'(count), 32'd0);
        send_pkt(30, 1, "cd", -1, 0, 0);
        chk("p14_load_lit", 32'(last_ld), 32'd0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
